// File: rtl/sel_arb_pkg.sv
// Shared types and helpers for the round-robin decoder-select arbiter.
// Used by sel_rr_arbiter and rr_pick.
package sel_arb_pkg;

    localparam int IDXW   = 6;
    localparam int MAXREQ = 1 << IDXW;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    typedef logic [IDXW-1:0] sel_idx_t;

    // Next search start: one past the winner, folding back to 0 after the last requester.
    function automatic sel_idx_t wrap_inc(input sel_idx_t idx, input int nreq);
        if (idx == sel_idx_t'(nreq - 1)) begin
            return '0;
        end
        return idx + sel_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest set request at or above ptr,
// falling back to the lowest set request overall when nothing sits at or above ptr.
module rr_pick
    import sel_arb_pkg::*;
#(
    parameter int NREQ = 64
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] masked_req;
    logic [NREQ-1:0] cand;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign mask[gi] = (sel_idx_t'(gi) >= ptr);
        end
    endgenerate

    assign masked_req = req & mask;
    assign cand       = (|masked_req) ? masked_req : req;
    assign valid      = |req;

    // Scanning downward leaves the lowest set candidate bit in idx.
    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                idx = sel_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/sel_rr_arbiter.sv
// Round-robin arbiter in front of the 6-to-64 select decoder, with one idle GAP cycle between owners.
// Optional grant-length limit enabled by defining GRANT_TIMEOUT_EN.
module sel_rr_arbiter
    import sel_arb_pkg::*;
#(
    parameter int NREQ     = 64,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            sel_en,
    output logic [IDXW-1:0] sel_idx,
    output logic            busy,
    output logic            timeout
);

    generate
        if (NREQ < 2 || NREQ > MAXREQ || MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_param
            $error("sel_rr_arbiter: NREQ must be 2..64 and MAX_HOLD 1..65535");
        end
    endgenerate

    arb_state_t      state_reg;
    sel_idx_t        ptr_reg;
    sel_idx_t        sel_idx_reg;
    logic [NREQ-1:0] gnt_reg;
    logic            sel_en_reg;

    logic            pick_valid;
    sel_idx_t        pick_idx;
    logic            owner_req;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_req = req[sel_idx_reg];

`ifdef GRANT_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

    logic [15:0] hold_cnt_reg;
    logic        timeout_reg;
    logic        expire;

    assign expire  = (hold_cnt_reg == HOLD_LAST);
    assign timeout = timeout_reg;

    // Counts completed GRANT cycles; zeroed while idle so each new grant starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
        end else if (state_reg == GRANT) begin
            hold_cnt_reg <= hold_cnt_reg + 16'd1;
        end else begin
            hold_cnt_reg <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            sel_idx_reg <= '0;
            gnt_reg     <= '0;
            sel_en_reg  <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
        end else begin
`ifdef GRANT_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        state_reg   <= GRANT;
                        gnt_reg     <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        sel_en_reg  <= 1'b1;
                        sel_idx_reg <= pick_idx;
                        ptr_reg     <= wrap_inc(pick_idx, NREQ);
                    end
                end
                GRANT: begin
                    // A release on the expiry edge wins, so no timeout pulse then.
                    if (!owner_req) begin
                        state_reg  <= GAP;
                        gnt_reg    <= '0;
                        sel_en_reg <= 1'b0;
                    end
`ifdef GRANT_TIMEOUT_EN
                    else if (expire) begin
                        state_reg   <= GAP;
                        gnt_reg     <= '0;
                        sel_en_reg  <= 1'b0;
                        timeout_reg <= 1'b1;
                    end
`endif
                end
                GAP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign sel_en  = sel_en_reg;
    assign sel_idx = sel_idx_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Self-checking bench for sel_rr_arbiter: directed steps plus random requests against a behavioural model.
// Timeout expectations follow GRANT_TIMEOUT_EN when the bench is built with it.
module tb_sel_rr_arbiter;

    localparam int NREQ     = 64;
    localparam int MAX_HOLD = 4;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            sel_en;
    logic [5:0]      sel_idx;
    logic            busy;
    logic            timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the path, where the next search starts, how long the owner has held it.
    int m_phase;   // 0 = no owner, 1 = owned, 2 = enforced idle cycle
    int m_ptr;
    int m_idx;
    int m_age;
    bit m_to;

    sel_rr_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel_en  (sel_en),
        .sel_idx (sel_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_idx   = 0;
        m_age   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [63:0] r);
        m_to = 1'b0;
        if (m_phase == 0) begin
            if (r != 64'd0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (r[(m_ptr + k) % NREQ]) begin
                        m_idx = (m_ptr + k) % NREQ;
                        break;
                    end
                end
                m_ptr   = (m_idx + 1) % NREQ;
                m_age   = 1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!r[m_idx]) begin
                m_phase = 2;
            end
`ifdef GRANT_TIMEOUT_EN
            else if (m_age == MAX_HOLD) begin
                m_phase = 2;
                m_to    = 1'b1;
            end
`endif
            else begin
                m_age++;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] exp_gnt;
        exp_gnt = (m_phase == 1) ? (64'd1 << m_idx) : 64'd0;
        check({tag, ".gnt"},     gnt, exp_gnt);
        check({tag, ".sel_en"},  64'(sel_en), 64'(m_phase == 1));
        check({tag, ".sel_idx"}, 64'(sel_idx), 64'(m_idx));
        check({tag, ".busy"},    64'(busy), 64'(m_phase != 0));
        check({tag, ".timeout"}, 64'(timeout), 64'(m_to));
    endtask

    // One clock: drive req away from the edge, let the model see the same edge, check on the falling edge.
    task automatic cycle(input logic [63:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '1;
        @(negedge clk);
        check("rst.gnt",     gnt, 64'd0);
        check("rst.sel_en",  64'(sel_en), 64'd0);
        check("rst.sel_idx", 64'(sel_idx), 64'd0);
        check("rst.busy",    64'(busy), 64'd0);
        check("rst.timeout", 64'(timeout), 64'd0);
        model_reset();
        req   = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] r;
        int          order[$];
        int          exp_order[5];
        int          w;
        int          owner;

        exp_order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        req   = '1;
        model_reset();

        // T1: reset with every requester asserted
        @(negedge clk);
        do_reset();

        // T2: single requester, one-cycle grant latency, release into GAP then IDLE
        cycle(64'd1 << 5, "T2.grant");
        check("T2.gnt5", gnt, 64'd1 << 5);
        check("T2.idx5", 64'(sel_idx), 64'd5);
        cycle(64'd1 << 5, "T2.hold");
        cycle(64'd0, "T2.release");
        check("T2.gap_gnt", gnt, 64'd0);
        check("T2.gap_busy", 64'(busy), 64'd1);
        cycle(64'd0, "T2.idle");
        check("T2.idle_busy", 64'(busy), 64'd0);
        check("T2.idle_idx", 64'(sel_idx), 64'd5);

        // T3: four requesters held, each owner releases after two grant cycles
        do_reset();
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (gnt == 64'd0 && w < 8) begin
                cycle(64'hF, "T3.wait");
                w++;
            end
            check("T3.latency", 64'(w), (g == 0) ? 64'd1 : 64'd2);
            owner = int'(sel_idx);
            order.push_back(owner);
            cycle(64'hF, "T3.hold");
            cycle(64'hF & ~(64'd1 << owner), "T3.release");
        end
        for (int g = 0; g < 5; g++) begin
            check("T3.order", 64'(order[g]), 64'(exp_order[g]));
        end
        cycle(64'd0, "T3.drain");

        // T4: pointer at 63 wraps to 0, then ptr lands at 3 after granting 2
        do_reset();
        cycle(64'd1 << 62, "T4.g62");
        cycle(64'd0, "T4.rel62");
        cycle(64'd0, "T4.gap");
        r = (64'd1 << 63) | (64'd1 << 2);
        cycle(r, "T4.g63");
        check("T4.idx63", 64'(sel_idx), 64'd63);
        cycle(64'd1 << 2, "T4.rel63");
        cycle(64'd1 << 2, "T4.gap2");
        cycle(64'd1 << 2, "T4.g2");
        check("T4.idx2", 64'(sel_idx), 64'd2);
        cycle(64'd0, "T4.rel2");
        cycle(64'd0, "T4.gap3");
        cycle(64'hC, "T4.g3");
        check("T4.idx3", 64'(sel_idx), 64'd3);
        cycle(64'd0, "T4.rel3");
        cycle(64'd0, "T4.gap4");

        // T5: requesters 1 and 7 held; bounded grant only when the timeout feature is built
        do_reset();
        r = (64'd1 << 1) | (64'd1 << 7);
        for (int i = 1; i <= 12; i++) begin
            cycle(r, "T5.step");
`ifdef GRANT_TIMEOUT_EN
            if (i <= 4) begin
                check("T5.own1", gnt, 64'd1 << 1);
            end else if (i == 5) begin
                check("T5.pulse", 64'(timeout), 64'd1);
                check("T5.revoked", gnt, 64'd0);
            end else if (i == 6) begin
                check("T5.gap", gnt, 64'd0);
                check("T5.pulse_end", 64'(timeout), 64'd0);
            end else if (i == 7) begin
                check("T5.own7", gnt, 64'd1 << 7);
            end
`else
            check("T5.own1", gnt, 64'd1 << 1);
            check("T5.no_to", 64'(timeout), 64'd0);
`endif
        end
        cycle(64'd0, "T5.rel");
        cycle(64'd0, "T5.gap");

        // T6: asynchronous reset while 9 owns the path, then restart from ptr 0
        do_reset();
        cycle(64'd1 << 9, "T6.g9");
        cycle(64'd1 << 9, "T6.hold");
        #2 rst_n = 1'b0;
        #1;
        check("T6.async_gnt", gnt, 64'd0);
        check("T6.async_en", 64'(sel_en), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        r = (64'd1 << 9) | 64'd1;
        cycle(r, "T6.regrant");
        check("T6.idx0", 64'(sel_idx), 64'd0);
        check("T6.gnt0", gnt, 64'd1);
        cycle(64'd0, "T6.rel");
        cycle(64'd0, "T6.gap");

        // Random sparse requests, held for a few cycles at a time
        r = 64'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) begin
                r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                if ($urandom_range(7) == 0) r = 64'd0;
            end
            cycle(r, "RND");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
